// File: rtl/chan_ctrl_pkg.sv
// Shared types and defaults for the channel dispense controller.
package chan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FLOW   = 2'd2,
        FLUSH  = 2'd3
    } chan_state_t;

    localparam int DEFAULT_VOL_W         = 16;
    localparam int DEFAULT_SETTLE_CYCLES = 8;
    localparam int DEFAULT_FLUSH_CYCLES  = 32;

    // Requested dispense volume, counted in pump cycles.
    typedef logic [DEFAULT_VOL_W-1:0] vol_t;

    // Larger of two integers, used to size the shared phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or above
// ptr (wrapping around) wins.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_valid
);

    localparam int IDX_W = $clog2(N_REQ);

    // Walk the requesters starting at ptr and keep only the first hit.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/channel_dispense_scheduler.sv
// Time-shares one microfluidic channel between N_REQ inlet requesters.
// Each dispense runs valve settle -> metered pump flow, followed by a wash
// flush when the CHANNEL_FLUSH_EN macro is defined.
module channel_dispense_scheduler
    import chan_ctrl_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int VOL_W         = $bits(vol_t),
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int FLUSH_CYCLES  = DEFAULT_FLUSH_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*VOL_W-1:0]   req_vol,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         valve_en,
    output logic                     pump_en,
    output logic                     flush_valve_en,
    output logic [N_REQ-1:0]         done,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int PH_MAX = max_int(SETTLE_CYCLES, FLUSH_CYCLES);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    chan_state_t      state, state_next;
    logic [VOL_W-1:0] vol_cnt;
    logic [PH_W-1:0]  phase_cnt;
    logic [IDX_W-1:0] ptr;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [VOL_W-1:0] sel_vol;
    logic             accept;
    logic [N_REQ-1:0] gnt_onehot;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req        (req_valid),
        .ptr        (ptr),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .grant_valid(arb_valid)
    );

    assign sel_vol    = req_vol[arb_idx*VOL_W +: VOL_W];
    assign accept     = (state == IDLE) && arb_valid && !rst;
    assign gnt_onehot = N_REQ'(1) << grant_id;

    assign req_ready = accept ? arb_grant : '0;
    assign valve_en  = ((state == SETTLE) || (state == FLOW)) ? gnt_onehot : '0;
    assign busy      = (state != IDLE);

`ifdef CHANNEL_FLUSH_EN
    assign pump_en        = (state == FLOW) || (state == FLUSH);
    assign flush_valve_en = (state == FLUSH);
`else
    assign pump_en        = (state == FLOW);
    assign flush_valve_en = 1'b0;
`endif

    // Next-state selection for the dispense sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (sel_vol != '0)) state_next = SETTLE;
            end
            SETTLE: begin
                if (phase_cnt == '0) state_next = FLOW;
            end
            FLOW: begin
`ifdef CHANNEL_FLUSH_EN
                if (vol_cnt == VOL_W'(1)) state_next = FLUSH;
`else
                if (vol_cnt == VOL_W'(1)) state_next = IDLE;
`endif
            end
`ifdef CHANNEL_FLUSH_EN
            FLUSH: begin
                if (phase_cnt == '0) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // State register, counters, latched grant, RR pointer and done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vol_cnt   <= '0;
            phase_cnt <= '0;
            ptr       <= '0;
            grant_id  <= '0;
            done      <= '0;
        end else begin
            state <= state_next;
            done  <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_id  <= arb_idx;
                        vol_cnt   <= sel_vol;
                        phase_cnt <= PH_W'(SETTLE_CYCLES - 1);
                        ptr       <= (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        if (sel_vol == '0) done <= arb_grant;
                    end
                end
                SETTLE: begin
                    if (phase_cnt != '0) phase_cnt <= phase_cnt - 1'b1;
                end
                FLOW: begin
                    vol_cnt <= vol_cnt - 1'b1;
                    if (vol_cnt == VOL_W'(1)) begin
                        done      <= gnt_onehot;
                        phase_cnt <= PH_W'(FLUSH_CYCLES - 1);
                    end
                end
`ifdef CHANNEL_FLUSH_EN
                FLUSH: begin
                    if (phase_cnt != '0) phase_cnt <= phase_cnt - 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
